// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: Game Boy LCD bus capture. Synchronizes and deglitches the raw
// LCD bus, tracks line/column and emits one framebuffer write per accepted pixel.
// Ports: clk/reset (sync, active-high); idata/iclk/ihsync/ivsync raw async bus;
// wraddress/wdata/wren framebuffer write port; frame_start/frame_done pulses;
// locked, err_overflow (sticky) status.
module gb_lcd_capture #(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 144,
    parameter int FILTER_LEN = 3,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        idata,
    input  logic              iclk,
    input  logic              ihsync,
    input  logic              ivsync,
    output logic [ADDR_W-1:0] wraddress,
    output logic [1:0]        wdata,
    output logic              wren,
    output logic              frame_start,
    output logic              frame_done,
    output logic              locked,
    output logic              err_overflow
);
    localparam int CW = $clog2(H_PIXELS + 1);
    localparam int LW = $clog2(V_LINES + 1);
    localparam int NW = $clog2(FILTER_LEN);

    localparam logic [CW-1:0] H_MAX  = CW'(H_PIXELS);
    localparam logic [LW-1:0] V_MAX  = LW'(V_LINES);
    localparam logic [LW-1:0] V_LAST = LW'(V_LINES - 1);
    localparam logic [NW-1:0] N_LAST = NW'(FILTER_LEN - 1);

    typedef enum logic {SEARCH, CAPTURE} state_t;

    // 2-FF synchronizers: {ivsync, ihsync, iclk, idata[1:0]}
    logic [4:0] sync1_q, sync2_q;
    // data delay line aligns data with the filtered iclk fall
    logic [1:0] dly_q [FILTER_LEN];

    // Filters, index 0: iclk, 1: ihsync, 2: ivsync
    logic [2:0]    raw_s;
    logic [2:0]    flt_q, flt_d;
    logic [2:0]    ev_q, ev_d;
    logic [NW-1:0] cnt_q [3];
    logic [NW-1:0] cnt_d [3];

    logic pix_ev, line_ev, frame_ev;

    state_t            state_q, state_d;
    logic [LW-1:0]     line_q, line_d;
    logic [CW-1:0]     col_q, col_d;
    logic              fcomp_q, fcomp_d;
    logic              ferr_q, ferr_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic              fs_q, fs_d;
    logic              fd_q, fd_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;
    logic              take_pix;

    assign raw_s    = sync2_q[4:2];
    assign pix_ev   = ev_q[0];
    assign line_ev  = ev_q[1];
    assign frame_ev = ev_q[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            for (int i = 0; i < FILTER_LEN; i++) dly_q[i] <= '0;
        end else begin
            sync1_q  <= {ivsync, ihsync, iclk, idata};
            sync2_q  <= sync1_q;
            dly_q[0] <= sync2_q[1:0];
            for (int i = 1; i < FILTER_LEN; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    // Flip only after FILTER_LEN consecutive opposite samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            flt_d[i] = flt_q[i];
            cnt_d[i] = '0;
            ev_d[i]  = 1'b0;
            if (raw_s[i] != flt_q[i]) begin
                if (cnt_q[i] == N_LAST) begin
                    flt_d[i] = raw_s[i];
                    // pixel clock acts on its fall, sync pulses on their rise
                    ev_d[i]  = (i == 0) ? ~raw_s[i] : raw_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + NW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flt_q <= '0;
            ev_q  <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            flt_q <= flt_d;
            ev_q  <= ev_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        col_d    = col_q;
        fcomp_d  = fcomp_q;
        ferr_d   = ferr_q;
        first_d  = first_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wren_d   = 1'b0;
        fs_d     = 1'b0;
        fd_d     = 1'b0;
        lock_d   = lock_q;
        err_d    = err_q;
        take_pix = 1'b0;

        if (frame_ev) begin
            if (state_q == CAPTURE) begin
                fd_d = fcomp_q;
                // the frame captured right after locking is not line-checked
                if (!first_q && line_q != V_MAX) err_d = 1'b1;
                first_d = 1'b0;
            end else begin
                first_d = 1'b1;
            end
            state_d  = CAPTURE;
            lock_d   = 1'b1;
            fs_d     = 1'b1;
            line_d   = '0;
            col_d    = '0;
            fcomp_d  = 1'b0;
            ferr_d   = 1'b0;
            take_pix = pix_ev;
        end else if (state_q == CAPTURE) begin
            // a latch with no pixels (e.g. alongside vsync) is absorbed
            if (line_ev && col_q != '0) begin
                if (col_q != H_MAX) begin
                    err_d  = 1'b1;
                    ferr_d = 1'b1;
                end
                if (line_q != V_MAX) line_d = line_q + LW'(1);
                if (line_q == V_LAST && !ferr_d) fcomp_d = 1'b1;
                col_d = '0;
            end
            take_pix = pix_ev;
        end

        // a coincident pixel lands in the new line/frame
        if (take_pix) begin
            if (col_d < H_MAX && line_d < V_MAX) begin
                addr_d  = ADDR_W'(32'(line_d) * 32'(H_PIXELS) + 32'(col_d));
                wdata_d = dly_q[FILTER_LEN-1];
                wren_d  = 1'b1;
            end else begin
                err_d  = 1'b1;
                ferr_d = 1'b1;
            end
            if (col_d != H_MAX) col_d = col_d + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            line_q  <= '0;
            col_q   <= '0;
            fcomp_q <= 1'b0;
            ferr_q  <= 1'b0;
            first_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            fcomp_q <= fcomp_d;
            ferr_q  <= ferr_d;
            first_q <= first_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    assign wraddress    = addr_q;
    assign wdata        = wdata_q;
    assign wren         = wren_q;
    assign frame_start  = fs_q;
    assign frame_done   = fd_q;
    assign locked       = lock_q;
    assign err_overflow = err_q;
endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb_gb_lcd_capture: self-checking bench for gb_lcd_capture.
// Default-geometry DUT plus a small 8x4, FILTER_LEN=2 DUT on the same bus.
module tb_gb_lcd_capture;
    localparam int H   = 160;
    localparam int V   = 144;
    localparam int F   = 3;
    localparam int AW  = 15;
    localparam int S_H = 8;
    localparam int S_V = 4;
    localparam int S_F = 2;
    localparam int S_A = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    idata = 2'd0;
    logic          iclk = 1'b1;
    logic          ihsync = 1'b0;
    logic          ivsync = 1'b0;
    logic [AW-1:0] wraddress;
    logic [1:0]    wdata;
    logic          wren, frame_start, frame_done, locked, err_overflow;
    logic [S_A-1:0] s_wraddress;
    logic [1:0]    s_wdata;
    logic          s_wren, s_fs, s_fd, s_locked, s_err;

    gb_lcd_capture dut (
        .clk(clk), .reset(reset), .idata(idata), .iclk(iclk),
        .ihsync(ihsync), .ivsync(ivsync), .wraddress(wraddress),
        .wdata(wdata), .wren(wren), .frame_start(frame_start),
        .frame_done(frame_done), .locked(locked),
        .err_overflow(err_overflow)
    );

    gb_lcd_capture #(
        .H_PIXELS(S_H), .V_LINES(S_V), .FILTER_LEN(S_F), .ADDR_W(S_A)
    ) dut_s (
        .clk(clk), .reset(reset), .idata(idata), .iclk(iclk),
        .ihsync(ihsync), .ivsync(ivsync), .wraddress(s_wraddress),
        .wdata(s_wdata), .wren(s_wren), .frame_start(s_fs),
        .frame_done(s_fd), .locked(s_locked), .err_overflow(s_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [1:0]    d;
    } wr_t;

    typedef struct {
        int lo;
        int eb;
        int es;
    } gvec_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  obs_rd = 0;
    int  b_wcnt = 0, fs_cnt = 0, fd_cnt = 0;
    int  s_wcnt = 0, s_last = 0, s_lastd = 0, s_fdc = 0, s_fdfs = 0;

    // behavioural model state (event level)
    bit m_lock, m_first, m_err;
    int m_line, m_col;

    always @(negedge clk) begin
        if (wren) begin
            obs_q.push_back({wraddress, wdata});
            b_wcnt++;
        end
        if (frame_start) fs_cnt++;
        if (frame_done) fd_cnt++;
        if (s_wren) begin
            s_wcnt++;
            s_last  = int'(s_wraddress);
            s_lastd = int'(s_wdata);
        end
        if (s_fd) s_fdc++;
        if (s_fd && s_fs) s_fdfs++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle;
        @(negedge clk);
        #2;
    endtask

    task automatic m_reset;
        m_lock  = 0;
        m_first = 0;
        m_err   = 0;
        m_line  = 0;
        m_col   = 0;
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic m_pix(input logic [1:0] d);
        wr_t w;
        if (!m_lock) return;
        if (m_col < H && m_line < V) begin
            w.a = AW'(m_line * H + m_col);
            w.d = d;
            exp_q.push_back(w);
        end else begin
            m_err = 1;
        end
        if (m_col < H) m_col++;
    endtask

    task automatic m_hs;
        if (!m_lock || m_col == 0) return;
        if (m_col != H) m_err = 1;
        if (m_line < V) m_line++;
        m_col = 0;
    endtask

    task automatic m_vs;
        if (m_lock && !m_first && m_line != V) m_err = 1;
        m_first = !m_lock;
        m_lock  = 1;
        m_line  = 0;
        m_col   = 0;
    endtask

    // data changes after the first low cycle; the first-low sample must win
    task automatic pix(input logic [1:0] d, input int lo, input int hi);
        m_pix(d);
        idata = d;
        iclk  = 1'b0;
        cyc(1);
        idata = ~d;
        cyc(lo - 1);
        iclk = 1'b1;
        cyc(hi);
    endtask

    task automatic hs;
        m_hs();
        ihsync = 1'b1;
        cyc(4);
        ihsync = 1'b0;
        cyc(4);
    endtask

    task automatic vs;
        m_vs();
        ivsync = 1'b1;
        cyc(4);
        ivsync = 1'b0;
        cyc(4);
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        iclk   = 1'b1;
        ihsync = 1'b0;
        ivsync = 1'b0;
        idata  = 2'd0;
        cyc(3);
        reset = 1'b0;
        cyc(10);
        settle();
        m_reset();
    endtask

    task automatic cmp_writes(input string nm);
        int n;
        n = obs_q.size() - obs_rd;
        chk({nm, " count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk($sformatf("%s addr[%0d]", nm, i),
                int'(obs_q[obs_rd+i].a), int'(exp_q[i].a));
            chk($sformatf("%s data[%0d]", nm, i),
                int'(obs_q[obs_rd+i].d), int'(exp_q[i].d));
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    initial begin
        gvec_t tbl[6];
        int b0, s0, fs0, sfd0, sfdfs0;
        int lat_b, lat_s, la, ld, n, kind;

        tbl[0] = '{1, 0, 0};
        tbl[1] = '{2, 0, 1};
        tbl[2] = '{3, 1, 1};
        tbl[3] = '{1, 0, 0};
        tbl[4] = '{4, 1, 1};
        tbl[5] = '{2, 0, 1};

        // reset state
        cyc(4);
        chk("rst wren", int'(wren), 0);
        chk("rst wraddress", int'(wraddress), 0);
        chk("rst wdata", int'(wdata), 0);
        chk("rst frame_start", int'(frame_start), 0);
        chk("rst frame_done", int'(frame_done), 0);
        chk("rst locked", int'(locked), 0);
        chk("rst err", int'(err_overflow), 0);
        chk("rst small locked", int'(s_locked), 0);
        reset = 1'b0;
        cyc(10);
        settle();
        m_reset();

        // pre-lock activity, then lock and two full lines
        hs();
        for (int i = 0; i < 5; i++) pix(2'(i), 4, 4);
        hs();
        settle();
        chk("prelock writes", obs_q.size() - obs_rd, 0);
        chk("prelock locked", int'(locked), 0);
        fs0 = fs_cnt;
        vs();
        settle();
        chk("lock locked", int'(locked), 1);
        chk("lock frame_start", fs_cnt - fs0, 1);
        for (int i = 0; i < H; i++) pix(2'(i % 4), 4, 4);
        hs();
        for (int i = 0; i < H; i++) pix(2'((i + 1) % 4), 4, 4);
        settle();
        cmp_writes("two lines");
        chk("two lines err", int'(err_overflow), 0);
        chk("two lines frame_start", fs_cnt - fs0, 1);
        chk("two lines frame_done", fd_cnt, 0);

        // latency of one pixel on both filter lengths
        do_reset();
        vs();
        m_pix(2'd2);
        idata = 2'd2;
        iclk  = 1'b0;
        lat_b = -1;
        lat_s = -1;
        la    = -1;
        ld    = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (wren && lat_b < 0) begin
                lat_b = k;
                la    = int'(wraddress);
                ld    = int'(wdata);
            end
            if (s_wren && lat_s < 0) lat_s = k;
        end
        iclk = 1'b1;
        cyc(8);
        chk("latency big", lat_b, 2 + F + 1);
        chk("latency small", lat_s, 2 + S_F + 1);
        chk("latency addr", la, 0);
        chk("latency data", ld, 2);

        // glitch table: low pulse widths around FILTER_LEN
        for (int r = 0; r < 6; r++) begin
            settle();
            b0 = b_wcnt;
            s0 = s_wcnt;
            if (tbl[r].eb != 0) m_pix(2'(r));
            idata = 2'(r);
            iclk  = 1'b0;
            cyc(tbl[r].lo);
            iclk = 1'b1;
            cyc(8);
            settle();
            chk($sformatf("glitch%0d big", r), b_wcnt - b0, tbl[r].eb);
            chk($sformatf("glitch%0d small", r), s_wcnt - s0, tbl[r].es);
        end
        pix(2'd3, 4, 4);
        settle();
        cmp_writes("glitch addrs");

        // 161st pixel, then a short line
        do_reset();
        vs();
        for (int i = 0; i < H; i++) pix(2'(i % 4), 4, 4);
        settle();
        chk("full line err", int'(err_overflow), 0);
        pix(2'd1, 4, 4);
        settle();
        chk("pixel 161 err", int'(err_overflow), 1);
        hs();
        for (int i = 0; i < 150; i++) pix(2'(i % 4), 4, 4);
        hs();
        settle();
        cmp_writes("overflow");
        chk("overflow err sticky", int'(err_overflow), int'(m_err));

        // small DUT: complete frame, then a broken one
        do_reset();
        vs();
        settle();
        s0     = s_wcnt;
        sfd0   = s_fdc;
        sfdfs0 = s_fdfs;
        for (int l = 0; l < S_V; l++) begin
            for (int p = 0; p < S_H; p++) pix(2'(p), 4, 4);
            hs();
        end
        vs();
        settle();
        chk("small frame writes", s_wcnt - s0, S_H * S_V);
        chk("small frame last addr", s_last, S_H * S_V - 1);
        chk("small frame last data", s_lastd, 3);
        chk("small frame_done", s_fdc - sfd0, 1);
        chk("small done with start", s_fdfs - sfdfs0, 1);
        chk("small frame err", int'(s_err), 0);
        s0   = s_wcnt;
        sfd0 = s_fdc;
        for (int p = 0; p < S_H + 1; p++) pix(2'(p), 4, 4);
        hs();
        for (int p = 0; p < S_H - 1; p++) pix(2'(p), 4, 4);
        hs();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < S_H; p++) pix(2'(p), 4, 4);
            hs();
        end
        vs();
        settle();
        chk("bad frame writes", s_wcnt - s0, S_H + (S_H - 1) + 2 * S_H);
        chk("bad frame_done", s_fdc - sfd0, 0);
        chk("bad frame err", int'(s_err), 1);

        // reset in the middle of a line
        do_reset();
        vs();
        for (int i = 0; i < 80; i++) pix(2'(i % 4), 4, 4);
        settle();
        cmp_writes("pre-reset");
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst wren", int'(wren), 0);
        chk("midrst wraddress", int'(wraddress), 0);
        chk("midrst wdata", int'(wdata), 0);
        chk("midrst frame_start", int'(frame_start), 0);
        chk("midrst frame_done", int'(frame_done), 0);
        chk("midrst locked", int'(locked), 0);
        chk("midrst err", int'(err_overflow), 0);
        reset = 1'b0;
        cyc(10);
        settle();
        m_reset();
        for (int i = 0; i < 10; i++) pix(2'(i % 4), 4, 4);
        hs();
        settle();
        cmp_writes("post-reset unlocked");
        chk("post-reset locked", int'(locked), 0);
        vs();
        pix(2'd3, 4, 4);
        settle();
        cmp_writes("relock");

        // randomized lines against the model
        do_reset();
        vs();
        for (int l = 0; l < 6; l++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) n = H;
            else if (kind == 1) n = int'($urandom_range(1, H - 1));
            else if (kind == 2) n = int'($urandom_range(H + 1, H + 4));
            else n = 0;
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(0, 4) == 0) begin
                    idata = 2'($urandom_range(0, 3));
                    iclk  = 1'b0;
                    cyc(int'($urandom_range(1, F - 1)));
                    iclk = 1'b1;
                    cyc(4);
                end
                pix(2'($urandom_range(0, 3)),
                    int'($urandom_range(F, F + 2)),
                    int'($urandom_range(F, F + 2)));
            end
            hs();
        end
        settle();
        cmp_writes("random");
        chk("random err", int'(err_overflow), int'(m_err));
        chk("random locked", int'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gb_lcd_capture.md
Name: gb_lcd_capture

Overview:
- Upstream input stage of the Game Boy to VGA path. It takes the raw asynchronous Game Boy LCD bus: pixel clock, latch/hsync, vsync and 2-bit data.
- It synchronizes and deglitches the bus, tracks line and column position, and emits one framebuffer write per accepted pixel as address, data and write enable.
- Its write port feeds the dual-port framebuffer, whose read side is scanned out by the VGA output stage. It also reports frame boundaries, lock status and geometry errors.

Parameters:
- H_PIXELS, 160, pixels per LCD line.
- V_LINES, 144, lines per LCD frame.
- FILTER_LEN, 3, consecutive agreeing synchronized samples required to change a filtered input state. Legal range is 2..8.
- ADDR_W, 15, framebuffer address width. Must hold H_PIXELS*V_LINES-1.

Ports:
- clk, input, 1, system clock; the same clock as the framebuffer write port.
- reset, input, 1, synchronous, active-high.
- idata, input, 2, raw LCD pixel data; asynchronous.
- iclk, input, 1, raw LCD pixel clock; data is valid at its falling edge; asynchronous.
- ihsync, input, 1, raw LCD line latch pulse; asynchronous.
- ivsync, input, 1, raw LCD frame sync; asynchronous.
- wraddress, output, ADDR_W, framebuffer write address = line*H_PIXELS + col.
- wdata, output, 2, pixel value to write.
- wren, output, 1, write strobe; high for exactly one cycle per accepted pixel.
- frame_start, output, 1, one-cycle pulse on an accepted vsync rise.
- frame_done, output, 1, one-cycle pulse when the frame just ended was geometrically complete.
- locked, output, 1, high once capture is synchronized to a frame.
- err_overflow, output, 1, sticky; a pixel or line fell outside H_PIXELS x V_LINES.

Behaviour:
- Reset: every output is 0. Filtered states are 0, counters are 0, state is SEARCH, and the synchronizers are flushed to 0. Reset mid-frame abandons the frame and requires a fresh vsync rise before any further writes.
- Synchronization: each of iclk, ihsync, ivsync and idata[1:0] passes through a 2-FF synchronizer.
- Data delay: idata has an additional FILTER_LEN-stage delay line, so captured data is the synchronized sample taken in the cycle of the first low iclk sample.
- Glitch filter per control input: the filtered state flips only after FILTER_LEN consecutive synchronized samples all equal the opposite value. The cycle of the flip is the edge-event cycle. A shorter run of opposite samples is ignored.
- Events:
  - PIX = filtered iclk 1->0.
  - LINE = filtered ihsync 0->1.
  - FRAME = filtered ivsync 0->1.
- State SEARCH: PIX and LINE are ignored and no writes occur. On FRAME: line and col go to 0, state goes to CAPTURE, locked=1 and frame_start pulses.
- State CAPTURE, PIX:
  - If col<H_PIXELS and line<V_LINES: register wraddress=line*H_PIXELS+col and wdata=the delayed data, and assert wren the next cycle.
  - Otherwise suppress the write and set err_overflow.
  - col increments, saturating at H_PIXELS.
- State CAPTURE, LINE:
  - If col==0, the event is ignored; this absorbs a latch pulse with no pixels, such as one coincident with vsync.
  - Otherwise: if col!=H_PIXELS, set err_overflow; then line increments (saturating at V_LINES) and col=0.
  - When line goes from V_LINES-1 to V_LINES, frame_complete=1, provided no error occurred in the frame.
- State CAPTURE, FRAME:
  - frame_done pulses if frame_complete.
  - frame_start pulses.
  - line=0, col=0, frame_complete cleared.
  - If the prior frame had a line count not equal to V_LINES, set err_overflow. The first frame after lock is exempt.
- Simultaneous events in one cycle:
  - FRAME has priority over LINE, and LINE is dropped.
  - A coincident PIX belongs to the new frame or line: it is written at address line_new*H_PIXELS+0 and col becomes 1.
- Latency: from a raw iclk fall to wren high is 2 (sync) + FILTER_LEN (filter) + 1 (output register) clk cycles.
- Stability: wraddress and wdata are stable and valid while wren=1; their values are don't-care otherwise. Consecutive wren pulses are separated by at least 2*FILTER_LEN cycles.
- Arithmetic: the address multiply is computed at full width and truncated to ADDR_W. line is 8 bits and col is 8 bits for the defaults; size them to log2 of V_LINES+1 and H_PIXELS+1.
- locked stays 1 until reset. err_overflow clears only on reset.

Test Plan:
- Reset, then 1 vsync rise and 160 iclk falls with idata cycling 0,1,2,3 -> wren pulses 160 times at addresses 0..159 with wdata 0,1,2,3 repeating; frame_start pulses once; locked=1; err_overflow=0.
- Pixels and hsync before the first vsync -> no wren, locked=0. After the vsync: 2 lines of 160 pixels each with an hsync between them -> the second line is written at addresses 160..319.
- A full 144x160 frame followed by a vsync rise -> 23040 writes, the last at address 23039; frame_done pulses once, coincident with frame_start.
- A 1-cycle and a 2-cycle low glitch on iclk with FILTER_LEN=3 -> no extra writes and col is unchanged. A 3-cycle low -> exactly one write.
- A 161st pixel in a line, then a line with 150 pixels -> pixel 161 is not written and err_overflow=1; the following frame_done is suppressed.
- Reset asserted mid-line at col=80 -> all outputs 0 next cycle and state SEARCH. Subsequent pixels are not written until a vsync rise, after which the first write goes to address 0.
